// File: rtl/l3_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// l3_arbiter_pkg
// Shared types for the L3 read-port arbiter.
//   BlockPos  : block-store address
//   BlockType : block-store data word
//   ArbState  : arbiter FSM state (IDLE / ISSUE / WAIT), 2-bit encoding
// -----------------------------------------------------------------------------
package l3_arbiter_pkg;

    typedef logic [15:0] BlockPos;
    typedef logic [31:0] BlockType;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ArbState;

endpackage

// File: rtl/l3_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// l3_arbiter_rr_picker
// Combinational round-robin picker: selects the first asserted request
// searching upward from ptr+1 (modulo N).
//   req      : request vector
//   ptr      : index of the most recent winner
//   grant    : one-hot winner
//   grant_id : binary index of the winner
//   any      : at least one request is asserted
// -----------------------------------------------------------------------------
module l3_arbiter_rr_picker #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no
        // path through the block leaves a signal unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        // Offset 1 visits ptr+1 first; offset N revisits ptr itself last.
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/l3_arbiter.sv
// -----------------------------------------------------------------------------
// l3_arbiter
// Shares the single L3 block-store read port among N requesters with
// round-robin arbitration and one outstanding read at a time. The L3 address
// is held until the read completes; the read is re-issued after TIMEOUT
// silent WAIT cycles (TIMEOUT=0 disables retry). Data returns on a shared bus
// with a one-hot, one-cycle valid.
//
// Ports:
//   clk_in, rst_in      : clock, asynchronous active-low reset
//   req_addr/req_valid  : per-requester address and request
//   req_ready           : one-hot accept (combinational, IDLE only)
//   resp_data/resp_valid: shared response data, one-hot valid pulse
//   l3_addr/l3_read_enable : L3 read address and one-cycle strobe
//   l3_out/l3_valid     : L3 read data and valid pulse
//   grant_count         : per-requester saturating grant counters
//                         (only when L3_ARB_STATS_EN is defined)
//
// Build option: define L3_ARB_STATS_EN to add the grant_count port/counters.
// -----------------------------------------------------------------------------
module l3_arbiter
    import l3_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
`ifdef L3_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  BlockPos [N-1:0]       req_addr,
    input  logic    [N-1:0]       req_valid,
    output logic    [N-1:0]       req_ready,
    output BlockType              resp_data,
    output logic    [N-1:0]       resp_valid,
    output BlockPos               l3_addr,
    output logic                  l3_read_enable,
    input  BlockType              l3_out,
    input  logic                  l3_valid
`ifdef L3_ARB_STATS_EN
    ,
    output logic [N-1:0][CNT_W-1:0] grant_count
`endif
);

    localparam int ID_W = $clog2(N);
    // Timer is sized for 0..TIMEOUT; keep at least one bit when retry is off.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    ArbState         state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id;
    logic [TW-1:0]   timer;

    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            any;

    l3_arbiter_rr_picker #(
        .N (N)
    ) u_picker (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    // Accept is offered only while idle and out of reset.
    assign req_ready = (state == IDLE && rst_in) ? grant : '0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            rr_ptr         <= ID_W'(N - 1);
            id             <= '0;
            timer          <= '0;
            l3_addr        <= '0;
            l3_read_enable <= 1'b0;
            resp_valid     <= '0;
            resp_data      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so each decision
            // below reads the pre-edge state and later defaults are
            // overridden cleanly by the case branches.
            resp_valid     <= '0;
            l3_read_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        id             <= grant_id;
                        rr_ptr         <= grant_id;
                        // l3_addr doubles as the latched request address.
                        l3_addr        <= req_addr[grant_id];
                        l3_read_enable <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe is already on the port this cycle; a stray
                    // l3_valid here is ignored.
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (l3_valid) begin
                        // A late answer from a timed-out attempt lands here
                        // too; it is for the same address, so accept it.
                        resp_data      <= l3_out;
                        resp_valid[id] <= 1'b1;
                        state          <= IDLE;
                    end else if (TIMEOUT != 0 && timer == TLAST) begin
                        l3_read_enable <= 1'b1;
                        state          <= ISSUE;
                    end else if (TIMEOUT != 0) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L3_ARB_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grant_count <= '0;
        end else if (state == IDLE && any && grant_count[grant_id] != '1) begin
            grant_count[grant_id] <= grant_count[grant_id] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_l3_arbiter.sv
module tb_l3_arbiter;
    import l3_arbiter_pkg::*;

    localparam int N       = 4;
    localparam int TIMEOUT = 4;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    BlockPos [N-1:0] req_addr;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    BlockType       resp_data;
    logic [N-1:0]   resp_valid;
    BlockPos        l3_addr;
    logic           l3_read_enable;
    BlockType       l3_out;
    logic           l3_valid;
`ifdef L3_ARB_STATS_EN
    logic [N-1:0][15:0] grant_count;
`endif

    l3_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_addr       (req_addr),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .l3_addr        (l3_addr),
        .l3_read_enable (l3_read_enable),
        .l3_out         (l3_out),
        .l3_valid       (l3_valid)
`ifdef L3_ARB_STATS_EN
        ,
        .grant_count    (grant_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic BlockType pat(input BlockPos a);
        return {a ^ 16'hC3A5, a};
    endfunction

    // ---------------- event logs (actual DUT activity) ----------------
    int      g_cyc[$];
    int      g_id[$];
    int      re_cyc[$];
    BlockPos re_addr[$];
    int      rv_cyc[$];
    int      rv_val[$];
    BlockType rv_data[$];

    task automatic clear_logs();
        g_cyc.delete(); g_id.delete(); re_cyc.delete(); re_addr.delete();
        rv_cyc.delete(); rv_val.delete(); rv_data.delete();
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Transaction view: one outstanding read, timestamps for the current
    // strobe and the pending response.
    bit       m_busy;
    int       m_id, m_ptr, m_issue, m_resp_cyc, m_resp_id;
    BlockPos  m_addr;
    BlockType m_data;
    int       m_cnt[N];
    int       win;
    logic [N-1:0] exp_ready, exp_rv;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            m_busy = 0; m_ptr = N - 1; m_addr = '0; m_data = '0; m_resp_cyc = -1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            check("reset_outputs", {req_ready, resp_valid, l3_read_enable, l3_addr, resp_data}, 64'd0);
`ifdef L3_ARB_STATS_EN
            check("reset_grant_count", 64'(grant_count), 64'd0);
`endif
        end else begin
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            exp_rv = '0;
            if (cyc == m_resp_cyc) exp_rv[m_resp_id] = 1'b1;

            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("l3_read_enable", 64'(l3_read_enable), 64'(m_busy && cyc == m_issue));
            check("l3_addr", 64'(l3_addr), 64'(m_addr));
            check("resp_valid", 64'(resp_valid), 64'(exp_rv));
            check("resp_data", 64'(resp_data), 64'(m_data));
`ifdef L3_ARB_STATS_EN
            for (int i = 0; i < N; i++)
                check("grant_count", 64'(grant_count[i]), 64'(m_cnt[i]));
`endif
            // actual-activity logs
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin g_cyc.push_back(cyc); g_id.push_back(i); end
                if (resp_valid[i]) begin rv_cyc.push_back(cyc); rv_val.push_back(int'(resp_valid)); rv_data.push_back(resp_data); end
            end
            if (l3_read_enable) begin re_cyc.push_back(cyc); re_addr.push_back(l3_addr); end

            // advance model to next cycle
            if (win >= 0) begin
                m_busy = 1; m_id = win; m_ptr = win; m_addr = req_addr[win]; m_issue = cyc + 1;
                if (m_cnt[win] < 65535) m_cnt[win]++;
            end else if (m_busy && cyc > m_issue) begin
                if (l3_valid) begin
                    m_busy = 0; m_resp_cyc = cyc + 1; m_resp_id = m_id; m_data = l3_out;
                end else if (cyc - m_issue == TIMEOUT) begin
                    m_issue = cyc + 1;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    bit       respond_en = 0;
    bit       rand_mode  = 0;
    int       fixed_delay = 1;
    int       due_cyc[$];
    BlockType due_dat[$];

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        logic [N-1:0] acc;
        #2;
        acc = req_valid & req_ready;
        @(posedge clk_in);
        #1;
        req_valid = req_valid & ~acc;
        l3_valid  = 1'b0;
        if (respond_en) begin
            if (l3_read_enable) begin
                due_cyc.push_back(cyc + (rand_mode ? int'($urandom_range(1, 7)) : fixed_delay));
                due_dat.push_back(pat(l3_addr));
            end
            for (int k = due_cyc.size() - 1; k >= 0; k--) begin
                if (due_cyc[k] <= cyc) begin
                    if (due_cyc[k] == cyc) begin l3_valid = 1'b1; l3_out = due_dat[k]; end
                    due_cyc.delete(k); due_dat.delete(k);
                end
            end
            if (rand_mode && !l3_valid && $urandom_range(0, 49) == 0) begin
                l3_valid = 1'b1; l3_out = $urandom;
            end
        end
    endtask

    int c0;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_s[7] = '{1, 1, 1, 1, 1, 3, 3};

    initial begin
        req_valid = '0; req_addr = '0; l3_valid = 1'b0; l3_out = '0;
        #1;
        req_valid = '1;
        #1;
        check("reset_ready_gated", 64'(req_ready), 64'd0);
        req_valid = '0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;

        // ---- all four requesting, L3 answers 2 cycles after the strobe ----
        clear_logs();
        fixed_delay = 2; respond_en = 1;
        for (int i = 0; i < N; i++) req_addr[i] = 16'h0100 + 16'(i);
        req_valid = '1;
        for (int t = 0; t < 40 && g_id.size() < 5; t++) begin
            tick();
            req_valid = '1;
        end
        req_valid = '0;
        repeat (10) tick();
        check("t1_grant_count", 64'(g_id.size()), 64'd5);
        for (int i = 0; i < 5 && i < g_id.size(); i++) check("t1_grant_order", 64'(g_id[i]), 64'(exp_g[i]));
        check("t1_resp_count", 64'(rv_val.size()), 64'd5);
        for (int i = 0; i < 4 && i < rv_val.size(); i++) begin
            check("t1_resp_onehot", 64'(rv_val[i]), 64'(1 << i));
            check("t1_resp_data", 64'(rv_data[i]), 64'(pat(16'h0100 + 16'(i))));
        end

        // ---- single requester 2, addr 0x15, L3 answers next cycle ----
        clear_logs();
        fixed_delay = 1;
        req_addr[2] = 16'h0015; req_valid = 4'b0100; c0 = cyc;
        repeat (6) tick();
        check("t2_grant_n", 64'(g_cyc.size()), 64'd1);
        if (g_cyc.size() > 0) begin
            check("t2_grant_cyc", 64'(g_cyc[0] - c0), 64'd0);
            check("t2_grant_id", 64'(g_id[0]), 64'd2);
        end
        check("t2_re_n", 64'(re_cyc.size()), 64'd1);
        if (re_cyc.size() > 0) begin
            check("t2_re_cyc", 64'(re_cyc[0] - c0), 64'd1);
            check("t2_re_addr", 64'(re_addr[0]), 64'h15);
        end
        check("t2_resp_n", 64'(rv_cyc.size()), 64'd1);
        if (rv_cyc.size() > 0) begin
            check("t2_resp_cyc", 64'(rv_cyc[0] - c0), 64'd3);
            check("t2_resp_val", 64'(rv_val[0]), 64'b0100);
            check("t2_resp_data", 64'(rv_data[0]), 64'hC3B0_0015);
        end

        // ---- L3 silent: strobes at +1, +6, +11; answer at +12 ----
        clear_logs();
        respond_en = 0;
        req_addr[1] = 16'h002A; req_valid = 4'b0010; c0 = cyc;
        repeat (12) tick();
        l3_valid = 1'b1; l3_out = pat(16'h002A);
        repeat (5) tick();
        check("t3_re_n", 64'(re_cyc.size()), 64'd3);
        for (int k = 0; k < 3 && k < re_cyc.size(); k++) begin
            check("t3_re_cyc", 64'(re_cyc[k] - c0), 64'(1 + 5 * k));
            check("t3_re_addr", 64'(re_addr[k]), 64'h2A);
        end
        check("t3_resp_n", 64'(rv_cyc.size()), 64'd1);
        if (rv_cyc.size() > 0) begin
            check("t3_resp_cyc", 64'(rv_cyc[0] - c0), 64'd13);
            check("t3_resp_val", 64'(rv_val[0]), 64'b0010);
        end

        // ---- stray l3_valid while idle ----
        clear_logs();
        l3_valid = 1'b1; l3_out = 32'hDEAD_BEEF;
        repeat (4) tick();
        check("t4_no_resp", 64'(rv_cyc.size()), 64'd0);
        check("t4_no_re", 64'(re_cyc.size()), 64'd0);
        req_addr[3] = 16'h0033; req_valid = 4'b1000;
        #1;
        check("t4_still_idle", 64'(req_ready), 64'b1000);
        respond_en = 1; fixed_delay = 1;
        repeat (6) tick();

        // ---- reset while waiting ----
        clear_logs();
        respond_en = 0;
        req_addr[2] = 16'h0044; req_valid = 4'b0100;
        repeat (3) tick();
        rst_in = 1'b0; req_valid = '1;
        #1;
        check("t5_reset_outputs", {req_ready, resp_valid, l3_read_enable, l3_addr, resp_data}, 64'd0);
        repeat (2) tick();
        req_valid = '0; rst_in = 1'b1;
        clear_logs(); due_cyc.delete(); due_dat.delete();
        tick();
        l3_valid = 1'b1; l3_out = pat(16'h0044);
        repeat (4) tick();
        check("t5_no_resp", 64'(rv_cyc.size()), 64'd0);
        check("t5_no_re", 64'(re_cyc.size()), 64'd0);
        req_valid = '1;
        #1;
        check("t5_first_grant_req0", 64'(req_ready), 64'b0001);
        respond_en = 1;
        tick();
        req_valid = '0;
        repeat (6) tick();

        // ---- grant statistics: 5 to requester 1, 2 to requester 3 ----
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        clear_logs();
        for (int k = 0; k < 7; k++) begin
            req_addr[exp_s[k]] = BlockPos'($urandom);
            req_valid = '0; req_valid[exp_s[k]] = 1'b1;
            repeat (5) tick();
        end
        check("t6_grant_n", 64'(g_id.size()), 64'd7);
        for (int k = 0; k < 7 && k < g_id.size(); k++) check("t6_grant_id", 64'(g_id[k]), 64'(exp_s[k]));
`ifdef L3_ARB_STATS_EN
        check("t6_count0", 64'(grant_count[0]), 64'd0);
        check("t6_count1", 64'(grant_count[1]), 64'd5);
        check("t6_count2", 64'(grant_count[2]), 64'd0);
        check("t6_count3", 64'(grant_count[3]), 64'd2);
`endif

        // ---- randomized traffic with retries, late and stray responses ----
        rand_mode = 1;
        repeat (2000) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1; req_addr[i] = BlockPos'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
        end
        rand_mode = 0; fixed_delay = 1; req_valid = '0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l3_arbiter.md
Name: l3_arbiter

Overview:
- Shares the single L3 block-store read port among N independent requesters, e.g. the 4 L2 miss paths and the world loader.
- Uses round-robin arbitration and allows one outstanding L3 read at a time.
- Holds the L3 address stable until the read completes, re-issues the read on timeout, and returns data on one shared response bus with one-hot valid.
- Sits between the l2_cache miss logic and the L3 port (l3_addr / l3_read_enable / l3_out / l3_valid).

Parameters:
- N, 4: number of requesters, 2..8.
- TIMEOUT, 64: WAIT cycles without l3_valid before re-issuing the read; 0 disables timeout.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, asynchronous assert, active-low.
- req_addr, input, N x BlockPos: per-requester read address.
- req_valid, input, N: request pending; must be held with a stable address until accepted.
- req_ready, output, N: one-hot accept; transfer occurs when req_valid[i] & req_ready[i].
- resp_data, output, BlockType: shared response data.
- resp_valid, output, N: one-hot, one-cycle pulse; resp_data is valid for requester i.
- l3_addr, output, BlockPos: L3 read address.
- l3_read_enable, output, 1: one-cycle read strobe.
- l3_out, input, BlockType: L3 read data.
- l3_valid, input, 1: L3 data valid, one-cycle pulse.
- grant_count, output, N x CNT_W: present only with L3_ARB_STATS_EN.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=IDLE, rr_ptr=N-1 (requester 0 wins first).
  - req_ready=0, resp_valid=0, l3_read_enable=0, l3_addr=0, resp_data=0, timer=0, grant_count=0.
- IDLE:
  - req_ready is combinational and is asserted only here, only to the winner.
  - Winner = first i with req_valid[i], searching from rr_ptr+1 modulo N.
  - On grant: latch id and addr, set rr_ptr=id, go to ISSUE. With no req_valid, stay in IDLE.
- ISSUE: l3_read_enable=1 for exactly one cycle, l3_addr=latched addr, timer cleared, go to WAIT.
- WAIT:
  - l3_addr holds its value; l3_read_enable=0.
  - If l3_valid: register resp_data<=l3_out and pulse resp_valid[id] on the next cycle, go to IDLE.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: go to ISSUE (re-issue the same addr). Else timer++.
- Back-to-back: resp_valid for request k and the grant of request k+1 may occur in the same cycle.
- Minimum latency:
  - Grant at cycle 0, read_enable at cycle 1.
  - With l3_valid at cycle 2, resp_valid is at cycle 3.
  - Throughput is at most one request per 3 cycles.
- l3_valid sampled in IDLE or ISSUE is ignored (stray or late response after a retry).
- A late l3_valid from a timed-out attempt that arrives in WAIT of the retry is accepted as the answer. This is safe because the address is identical.
- A requester dropping req_valid before acceptance is legal; it is not granted.
- An accepted request cannot be cancelled.
- Reset mid-operation drops the outstanding request; no resp_valid is issued. Requesters must re-request.
- Round-robin guarantee: with all N requesting continuously, each requester is granted exactly once per N grants.
- Timer width is clog2(TIMEOUT+1); the timer never wraps because it is cleared in ISSUE.

Optional Feature:
- L3_ARB_STATS_EN defined:
  - grant_count[i] increments on each grant to i, saturating at 2^CNT_W-1.
  - It is cleared only by reset.
- Undefined: grant_count port and counters are absent; arbitration is identical.

Decomposition:
- Package types.sv:
  - Existing: BlockPos, BlockType.
  - New: ArbState enum {IDLE, ISSUE, WAIT}, encoded 2 bits.
- Sub-module rr_picker (combinational):
  - Inputs: req[N], ptr.
  - Outputs: grant one-hot, grant_id, any.

Test Plan:
- Reset, then req_valid=4'b1111 held with distinct addrs, L3 returns after 2 cycles.
  - Grants ordered 0,1,2,3,0.
  - Each resp_valid goes to the matching bit with data equal to the addr-derived pattern.
- Only requester 2, addr=0x15, l3_valid 1 cycle after read_enable.
  - req_ready[2] at cycle 0, l3_read_enable at cycle 1 with l3_addr=0x15.
  - resp_valid=4'b0100 at cycle 3.
- TIMEOUT=4, L3 silent for 10 cycles, then l3_valid.
  - l3_read_enable pulses at cycles 1, 6, 11 with the same addr.
  - Exactly one resp_valid.
- l3_valid pulse while IDLE with no requests: no resp_valid, state stays IDLE.
- rst_in low while in WAIT, release, then l3_valid.
  - All outputs 0 during reset; no resp_valid after release.
  - Next grant goes to requester 0.
- With L3_ARB_STATS_EN: 5 grants to requester 1 and 2 grants to requester 3 give grant_count[1]=5, grant_count[3]=2, others 0.
